// File: rtl/pr_multi_unit_pkg.sv
// rca_config: shared definitions for the RCA fabric PR units.
//   pr_op_t            reduction operation select (3-bit)
//   N_IN_MIN/MAX       legal range of input channel count
//   LATENCY_MIN/MAX    legal range of result pipeline depth
package rca_config;

  typedef enum logic [2:0] {
    PR_ADD  = 3'd0,
    PR_SUB  = 3'd1,
    PR_AND  = 3'd2,
    PR_OR   = 3'd3,
    PR_XOR  = 3'd4,
    PR_MAXU = 3'd5,
    PR_MINU = 3'd6,
    PR_PASS = 3'd7
  } pr_op_t;

  localparam int N_IN_MIN    = 1;
  localparam int N_IN_MAX    = 4;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

endpackage

// File: rtl/pr_operand_slot.sv
// pr_operand_slot: one-entry operand buffer with a full flag.
//   clk, rst   clock, asynchronous active-high reset (clears full only)
//   capture    load din and mark full
//   clear      mark empty (the operand has been consumed)
//   din        operand to capture
//   full       slot holds a valid operand
//   dout       held operand
module pr_operand_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic [DATA_W-1:0] dout
);

  // Capture wins over clear so a consumed slot can be refilled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/pr_multi_unit.sv
// pr_multi_unit: reconfigurable reduction unit with N_IN operand channels.
//   clk, rst         clock, asynchronous active-high reset
//   cfg_we           config write strobe (accepted only when idle and mask != 0)
//   cfg_op           operation select (rca_config::pr_op_t encoding)
//   cfg_in_mask      channels taking part in the operation
//   cfg_busy         any operand slot full or any pipeline stage valid
//   data_in          one operand per channel
//   data_valid_in    operand valid per channel
//   data_in_ack      operand captured this cycle, per channel
//   data_out         result
//   data_valid_out   result valid
//   data_out_ready   downstream accepts result
module pr_multi_unit
  import rca_config::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_IN    = 2,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_op,
  input  logic [N_IN-1:0]             cfg_in_mask,
  output logic                        cfg_busy,
  input  logic [N_IN-1:0][DATA_W-1:0] data_in,
  input  logic [N_IN-1:0]             data_valid_in,
  output logic [N_IN-1:0]             data_in_ack,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid_out,
  input  logic                        data_out_ready
);

  pr_op_t                      op_q;
  logic [N_IN-1:0]             mask_q;
  logic [N_IN-1:0]             full;
  logic [N_IN-1:0][DATA_W-1:0] slot_data;
  logic [N_IN-1:0]             slot_clr;
  logic                        adv;
  logic                        fire;
  logic [DATA_W-1:0]           red_res;
  logic [LATENCY-1:0]          stage_vld;
  logic [DATA_W-1:0]           stage_data [LATENCY];

  // Fold the masked operands in ascending channel order; the lowest masked
  // operand seeds the accumulator, which gives SUB and PASS their meaning.
  function automatic logic [DATA_W-1:0] reduce(
    input pr_op_t                      op,
    input logic [N_IN-1:0]             m,
    input logic [N_IN-1:0][DATA_W-1:0] d
  );
    logic [DATA_W-1:0] acc;
    logic              first;
    acc   = '0;
    first = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (m[i]) begin
        if (first) begin
          acc   = d[i];
          first = 1'b0;
        end else begin
          case (op)
            PR_ADD:  acc = acc + d[i];
            PR_SUB:  acc = acc - d[i];
            PR_AND:  acc = acc & d[i];
            PR_OR:   acc = acc | d[i];
            PR_XOR:  acc = acc ^ d[i];
            PR_MAXU: acc = (d[i] > acc) ? d[i] : acc;
            PR_MINU: acc = (d[i] < acc) ? d[i] : acc;
            PR_PASS: acc = acc;
          endcase
        end
      end
    end
    return acc;
  endfunction

  // Config only changes between operations so in-flight work keeps its op/mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= PR_ADD;
      mask_q <= '1;
    end else if (cfg_we && !cfg_busy && (cfg_in_mask != '0)) begin
      op_q   <= pr_op_t'(cfg_op);
      mask_q <= cfg_in_mask;
    end
  end

  assign adv      = !(data_valid_out && !data_out_ready);
  assign fire     = adv && (&(full | ~mask_q));
  assign slot_clr = {N_IN{fire}} & mask_q;
  // Acks are held low during reset so nothing appears captured while slots are cleared.
  assign data_in_ack = {N_IN{!rst}} & data_valid_in & mask_q & (~full | {N_IN{fire}});

  for (genvar i = 0; i < N_IN; i++) begin : g_slot
    pr_operand_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .capture(data_in_ack[i]),
      .clear  (slot_clr[i]),
      .din    (data_in[i]),
      .full   (full[i]),
      .dout   (slot_data[i])
    );
  end

  assign red_res = reduce(op_q, mask_q, slot_data);

  // Result pipeline: every stage advances together on adv.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic              vld_p;
    logic [DATA_W-1:0] data_p;
    logic              vld_nxt;
    logic [DATA_W-1:0] data_nxt;

    if (k == 0) begin : g_head
      assign vld_nxt  = fire;
      assign data_nxt = red_res;
    end else begin : g_tail
      assign vld_nxt  = stage_vld[k-1];
      assign data_nxt = stage_data[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p  <= 1'b0;
        data_p <= '0;
      end else if (adv) begin
        vld_p  <= vld_nxt;
        data_p <= data_nxt;
      end
    end

    assign stage_vld[k]  = vld_p;
    assign stage_data[k] = data_p;
  end

  assign data_out       = stage_data[LATENCY-1];
  assign data_valid_out = stage_vld[LATENCY-1];
  assign cfg_busy       = (|full) | (|stage_vld);

endmodule

// File: tb/tb_pr_multi_unit.sv
// Bench for pr_multi_unit: instance A (N_IN=2, LATENCY=1) and instance B
// (N_IN=4, LATENCY=3) share clock and reset. Expected results are queued
// when operands are driven and checked by per-instance output monitors.
module tb_pr_multi_unit;
  import rca_config::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              a_cfg_we, a_busy, a_vout, a_rdy;
  logic [2:0]        a_cfg_op;
  logic [1:0]        a_cfg_mask, a_dv, a_ack;
  logic [1:0][DW-1:0] a_din;
  logic [DW-1:0]     a_dout;

  logic              b_cfg_we, b_busy, b_vout, b_rdy;
  logic [2:0]        b_cfg_op;
  logic [3:0]        b_cfg_mask, b_dv, b_ack;
  logic [3:0][DW-1:0] b_din;
  logic [DW-1:0]     b_dout;

  pr_multi_unit #(.DATA_W(DW), .N_IN(2), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .cfg_we(a_cfg_we), .cfg_op(a_cfg_op), .cfg_in_mask(a_cfg_mask),
    .cfg_busy(a_busy), .data_in(a_din), .data_valid_in(a_dv), .data_in_ack(a_ack),
    .data_out(a_dout), .data_valid_out(a_vout), .data_out_ready(a_rdy)
  );

  pr_multi_unit #(.DATA_W(DW), .N_IN(4), .LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_op(b_cfg_op), .cfg_in_mask(b_cfg_mask),
    .cfg_busy(b_busy), .data_in(b_din), .data_valid_in(b_dv), .data_in_ack(b_ack),
    .data_out(b_dout), .data_valid_out(b_vout), .data_out_ready(b_rdy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  typedef struct {
    logic [2:0]         op;
    logic [3:0]         mask;
    logic [3:0][DW-1:0] d;
    logic [DW-1:0]      exp;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input logic [2:0] op, input logic [1:0] m);
    a_cfg_we = 1'b1; a_cfg_op = op; a_cfg_mask = m;
    tick();
    a_cfg_we = 1'b0;
  endtask

  task automatic cfg_b(input logic [2:0] op, input logic [3:0] m);
    b_cfg_we = 1'b1; b_cfg_op = op; b_cfg_mask = m;
    tick();
    b_cfg_we = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (a_busy && n < 100) begin tick(); n++; end
    check(name, 32'(a_busy), 32'd0);
  endtask

  task automatic wait_idle_b(input string name);
    int n = 0;
    while (b_busy && n < 100) begin tick(); n++; end
    check(name, 32'(b_busy), 32'd0);
  endtask

  // Output monitors: every accepted result must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && a_vout && a_rdy) begin
      if (qa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected: got %h, required no result", a_dout);
      end else begin
        check("a_result", a_dout, qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_vout && b_rdy) begin
      if (qb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected: got %h, required no result", b_dout);
      end else begin
        check("b_result", b_dout, qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hold;

    vt[0] = '{PR_ADD,  4'b1111, {32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF}, 32'h0};
    vt[1] = '{PR_MINU, 4'b1111, {32'h2, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000}, 32'h1};
    vt[2] = '{PR_MAXU, 4'b1111, {32'h2, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000}, 32'hFFFF_FFFF};
    vt[3] = '{PR_SUB,  4'b1111, {32'd3, 32'd2, 32'd1, 32'd100}, 32'd94};
    vt[4] = '{PR_SUB,  4'b0110, {32'd1, 32'd8, 32'd50, 32'd100}, 32'd42};
    vt[5] = '{PR_AND,  4'b1011, {32'h0FF0_F0F0, 32'h1234_5678, 32'hFF00_FF00, 32'hF0F0_FFFF}, 32'h0000_F000};
    vt[6] = '{PR_OR,   4'b0101, {32'hFFFF_0000, 32'h1100, 32'hFFFF_FFFF, 32'h11}, 32'h1111};
    vt[7] = '{PR_XOR,  4'b1111, {32'h1, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 32'hA5A5_A5A5}, 32'h1};
    vt[8] = '{PR_PASS, 4'b1100, {32'd4, 32'd3, 32'd2, 32'd1}, 32'd3};
    vt[9] = '{PR_ADD,  4'b1000, {32'h77, 32'd1, 32'd2, 32'd3}, 32'h77};

    rst = 1'b1;
    a_cfg_we = 0; a_cfg_op = 0; a_cfg_mask = 0; a_din = '0; a_dv = 0; a_rdy = 1;
    b_cfg_we = 0; b_cfg_op = 0; b_cfg_mask = 0; b_din = '0; b_dv = 0; b_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_vout", 32'(a_vout), 32'd0);
    check("a_rst_ack",  32'(a_ack),  32'd0);
    check("a_rst_busy", 32'(a_busy), 32'd0);
    check("a_rst_dout", a_dout,      32'd0);
    check("b_rst_vout", 32'(b_vout), 32'd0);
    check("b_rst_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;
    tick();

    // A: ADD 5+7, two-cycle latency.
    a_din[0] = 32'd5; a_din[1] = 32'd7; a_dv = 2'b11; qa.push_back(32'd12);
    @(negedge clk); check("a_ack_both", 32'(a_ack), 32'd3);
    tick(); a_dv = 2'b00;
    @(negedge clk); check("a_lat_early", 32'(a_vout), 32'd0);
    tick();
    @(negedge clk); check("a_lat_valid", 32'(a_vout), 32'd1);
    wait_idle_a("a_idle_add");

    // A: staggered SUB, slot 0 holds while channel 0 keeps offering data.
    cfg_a(PR_SUB, 2'b11);
    a_din[0] = 32'd10; a_dv = 2'b01; qa.push_back(32'd7);
    @(negedge clk); check("a_stag_ack0", 32'(a_ack), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); a_din[0] = 32'd99; a_dv = 2'b01;
      @(negedge clk);
      check("a_stag_hold_ack", 32'(a_ack), 32'd0);
      check("a_stag_no_out", 32'(a_vout), 32'd0);
    end
    tick(); a_din[1] = 32'd3; a_dv = 2'b10;
    @(negedge clk); check("a_stag_ack1", 32'(a_ack), 32'd2);
    tick(); a_dv = 2'b00;
    @(negedge clk); check("a_stag_fire_no_out", 32'(a_vout), 32'd0);
    tick();
    @(negedge clk); check("a_stag_out", 32'(a_vout), 32'd1);
    wait_idle_a("a_idle_stag");

    // A: config gating.
    cfg_a(PR_ADD, 2'b11);
    a_din[0] = 32'd20; a_din[1] = 32'd22; a_dv = 2'b11; qa.push_back(32'd42);
    tick(); a_dv = 2'b00;
    a_cfg_we = 1'b1; a_cfg_op = PR_MAXU; a_cfg_mask = 2'b01;
    @(negedge clk); check("a_busy_inflight", 32'(a_busy), 32'd1);
    tick(); a_cfg_we = 1'b0;
    wait_idle_a("a_idle_g1");
    a_din[0] = 32'd4; a_din[1] = 32'd6; a_dv = 2'b11; qa.push_back(32'd10);
    @(negedge clk); check("a_cfg_dropped_ack", 32'(a_ack), 32'd3);
    tick(); a_dv = 2'b00;
    wait_idle_a("a_idle_g2");
    cfg_a(PR_MAXU, 2'b01);
    a_din[0] = 32'd9; a_din[1] = 32'd100; a_dv = 2'b11; qa.push_back(32'd9);
    @(negedge clk); check("a_mask01_ack", 32'(a_ack), 32'd1);
    tick(); a_dv = 2'b00;
    wait_idle_a("a_idle_g3");
    cfg_a(PR_ADD, 2'b00);
    a_din[0] = 32'd5; a_din[1] = 32'd50; a_dv = 2'b11; qa.push_back(32'd5);
    @(negedge clk); check("a_mask0_dropped_ack", 32'(a_ack), 32'd1);
    tick(); a_dv = 2'b00;
    wait_idle_a("a_idle_g4");

    // B: table of operations, wrap and unsigned compares.
    for (int i = 0; i < 10; i++) begin
      cfg_b(vt[i].op, vt[i].mask);
      b_din = vt[i].d; b_dv = 4'b1111; qb.push_back(vt[i].exp);
      @(negedge clk); check($sformatf("b_vec%0d_ack", i), 32'(b_ack), 32'(vt[i].mask));
      tick(); b_dv = 4'b0000;
      wait_idle_b($sformatf("b_vec%0d_idle", i));
    end

    // B: streaming with a 5-cycle backpressure window.
    cfg_b(PR_ADD, 4'b0011);
    fork
      begin
        int i0 = 0;
        int i1 = 0;
        int cyc = 0;
        while ((i0 < 8 || i1 < 8) && cyc < 200) begin
          b_din[0] = 32'(i0 * 3 + 1);
          b_din[1] = 32'(i1 * 5 + 100);
          b_dv = {2'b00, (i1 < 8), (i0 < 8)};
          @(negedge clk);
          if (b_ack[0]) begin qb.push_back(32'(i0 * 8 + 101)); i0++; end
          if (b_ack[1]) i1++;
          tick(); cyc++;
        end
        b_dv = 4'b0000;
        check("b_stream_sent", 32'(i0 + i1), 32'd16);
      end
      begin
        repeat (5) tick();
        b_rdy = 1'b0;
        @(negedge clk);
        hold = b_dout;
        check("b_stall_valid", 32'(b_vout), 32'd1);
        check("b_stall_ack", 32'(b_ack), 32'd0);
        for (int k = 1; k < 5; k++) begin
          tick();
          @(negedge clk);
          check("b_stall_valid", 32'(b_vout), 32'd1);
          check("b_stall_stable", b_dout, hold);
          check("b_stall_ack", 32'(b_ack), 32'd0);
        end
        tick(); b_rdy = 1'b1;
      end
    join
    wait_idle_b("b_idle_stream");
    check("b_stream_drained", 32'(qb.size()), 32'd0);

    // B: asynchronous reset between edges with two results in flight.
    b_din[0] = 32'd1; b_din[1] = 32'd2; b_dv = 4'b0011;
    tick(); b_din[0] = 32'd3; b_din[1] = 32'd4;
    tick(); b_din[0] = 32'd5; b_din[1] = 32'd6;
    check("b_busy_before_rst", 32'(b_busy), 32'd1);
    #2; rst = 1'b1; #1;
    check("b_arst_vout", 32'(b_vout), 32'd0);
    check("b_arst_ack",  32'(b_ack),  32'd0);
    check("b_arst_busy", 32'(b_busy), 32'd0);
    check("b_arst_dout", b_dout,      32'd0);
    qb.delete();
    b_dv = 4'b0000;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("b_post_rst_no_out", 32'(b_vout), 32'd0);
      tick();
    end

    // B: config back at ADD / all channels after reset.
    b_din = {32'd4, 32'd3, 32'd2, 32'd1}; b_dv = 4'b1111; qb.push_back(32'd10);
    @(negedge clk); check("b_post_rst_ack", 32'(b_ack), 32'hF);
    tick(); b_dv = 4'b0000;
    wait_idle_b("b_idle_final");

    check("qa_empty", 32'(qa.size()), 32'd0);
    check("qb_empty", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
